// File: rtl/minhash_pkg.sv
// Shared definitions for the min-hash front end: base encoding, hash constants
// and the golden signature function used by benches.
package minhash_pkg;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    localparam logic [31:0] HASH_SEED = 32'h9E3779B1;
    localparam logic [31:0] HASH_MULT = 32'h85EBCA6B;

    function automatic logic [31:0] hash_ref(input logic [31:0] kmer);
        logic [31:0] prod;
        prod = (kmer ^ HASH_SEED) * HASH_MULT;
        return prod ^ (prod >> 15);
    endfunction

endpackage

// File: rtl/kmer_hash_mix.sv
// Two-stage hash mix (multiply, then xor-shift) carrying valid, index and
// end-of-sequence sidebands alongside the signature.
module kmer_hash_mix
    import minhash_pkg::*;
#(
    parameter int SIGNATURE_WIDTH = 32,
    parameter int INDEX_WIDTH     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    input  logic [SIGNATURE_WIDTH-1:0] kmer,
    input  logic [INDEX_WIDTH-1:0]     index,
    input  logic                       last,
    output logic                       sig_valid,
    output logic [SIGNATURE_WIDTH-1:0] signature,
    output logic [INDEX_WIDTH-1:0]     sig_index,
    output logic                       done
);

    localparam logic [SIGNATURE_WIDTH-1:0] SEED = SIGNATURE_WIDTH'(HASH_SEED);
    localparam logic [SIGNATURE_WIDTH-1:0] MULT = SIGNATURE_WIDTH'(HASH_MULT);

    logic [SIGNATURE_WIDTH-1:0] prod;
    logic [INDEX_WIDTH-1:0]     prod_index;
    logic                       prod_valid;
    logic                       prod_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod       <= '0;
            prod_index <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else begin
            prod_valid <= valid;
            prod_last  <= last;
            if (valid) begin
                prod       <= (kmer ^ SEED) * MULT;
                prod_index <= index;
            end
        end
    end

    // signature/index hold their last value between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_valid <= 1'b0;
            signature <= '0;
            sig_index <= '0;
            done      <= 1'b0;
        end else begin
            sig_valid <= prod_valid;
            done      <= prod_last;
            if (prod_valid) begin
                signature <= prod ^ (prod >> 15);
                sig_index <= prod_index;
            end
        end
    end

endmodule

// File: rtl/kmer_hasher.sv
// Rolling K-mer window over a 2-bit base stream feeding the hash mix pipeline.
// Optional CANONICAL_KMER_EN hashes min(forward, reverse complement).
module kmer_hasher
    import minhash_pkg::*;
#(
    parameter int K               = 16,
    parameter int SIGNATURE_WIDTH = 32,
    parameter int INDEX_WIDTH     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [1:0]                 in_base,
    input  logic                       in_last,
    output logic                       valid_out,
    output logic [SIGNATURE_WIDTH-1:0] signature_out,
    output logic [INDEX_WIDTH-1:0]     index_out,
    output logic                       seq_done
);

    localparam int FILL_WIDTH = $clog2(K + 1);
    localparam int WIN_WIDTH  = 2 * K;

    logic [WIN_WIDTH-1:0]   window;
    logic [WIN_WIDTH-1:0]   kmer;
    logic [FILL_WIDTH-1:0]  fill;
    logic [FILL_WIDTH-1:0]  fill_inc;
    logic [INDEX_WIDTH-1:0] pos;
    logic [INDEX_WIDTH-1:0] kmer_index;
    logic                   kmer_valid;
    logic                   kmer_last;

    always_comb begin
        fill_inc = (fill == FILL_WIDTH'(K)) ? fill : fill + FILL_WIDTH'(1);
    end

    // fill/pos restart after in_last; stale window bits shift out before fill reaches K
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window     <= '0;
            fill       <= '0;
            pos        <= '0;
            kmer_index <= '0;
            kmer_valid <= 1'b0;
            kmer_last  <= 1'b0;
        end else begin
            kmer_valid <= 1'b0;
            kmer_last  <= 1'b0;
            if (in_valid) begin
                window     <= {window[WIN_WIDTH-3:0], in_base};
                kmer_valid <= (fill_inc == FILL_WIDTH'(K));
                kmer_index <= pos - INDEX_WIDTH'(K - 1);
                kmer_last  <= in_last;
                if (in_last) begin
                    fill <= '0;
                    pos  <= '0;
                end else begin
                    fill <= fill_inc;
                    pos  <= pos + INDEX_WIDTH'(1);
                end
            end
        end
    end

`ifdef CANONICAL_KMER_EN
    logic [WIN_WIDTH-1:0] rc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc <= '0;
        end else if (in_valid) begin
            rc <= {~in_base, rc[WIN_WIDTH-1:2]};
        end
    end

    assign kmer = (rc < window) ? rc : window;
`else
    assign kmer = window;
`endif

    kmer_hash_mix #(
        .SIGNATURE_WIDTH (SIGNATURE_WIDTH),
        .INDEX_WIDTH     (INDEX_WIDTH)
    ) u_mix (
        .clk       (clk),
        .rst       (rst),
        .valid     (kmer_valid),
        .kmer      (SIGNATURE_WIDTH'(kmer)),
        .index     (kmer_index),
        .last      (kmer_last),
        .sig_valid (valid_out),
        .signature (signature_out),
        .sig_index (index_out),
        .done      (seq_done)
    );

endmodule

// File: tb/tb_kmer_hasher.sv
// Directed bench for kmer_hasher (K=4) with a scoreboard of expected output
// pulses, each tagged with the cycle it must appear in.
module tb_kmer_hasher;
    import minhash_pkg::*;

    localparam int K  = 4;
    localparam int SW = 32;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    in_base = 2'd0;
    logic          in_last = 1'b0;
    logic          valid_out;
    logic [SW-1:0] signature_out;
    logic [IW-1:0] index_out;
    logic          seq_done;

    kmer_hasher #(.K(K), .SIGNATURE_WIDTH(SW), .INDEX_WIDTH(IW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_base       (in_base),
        .in_last       (in_last),
        .valid_out     (valid_out),
        .signature_out (signature_out),
        .index_out     (index_out),
        .seq_done      (seq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          v;
        logic          d;
        logic [SW-1:0] sig;
        logic [IW-1:0] idx;
        int            at;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [SW-1:0] held_sig = '0;
    logic [IW-1:0] held_idx = '0;

    function automatic logic [7:0] canon(input logic [7:0] k);
`ifdef CANONICAL_KMER_EN
        logic [7:0] rc;
        for (int i = 0; i < 4; i++) rc[2*i +: 2] = ~k[6-2*i +: 2];
        return (rc < k) ? rc : k;
`else
        return k;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && (valid_out === 1'b1 || seq_done === 1'b1)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_output cyc=%0d valid=%b done=%b sig=%h idx=%0d required none",
                       cyc, valid_out, seq_done, signature_out, index_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                assert (cyc === e.at) else begin
                    bad++; $error("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, e.at);
                end
                total++;
                assert (valid_out === e.v) else begin
                    bad++; $error("FAIL valid_out got=%b exp=%b", valid_out, e.v);
                end
                total++;
                assert (seq_done === e.d) else begin
                    bad++; $error("FAIL seq_done got=%b exp=%b", seq_done, e.d);
                end
                total++;
                assert (signature_out === e.sig) else begin
                    bad++; $error("FAIL signature got=%h exp=%h", signature_out, e.sig);
                end
                total++;
                assert (index_out === e.idx) else begin
                    bad++; $error("FAIL index got=%0d exp=%0d", index_out, e.idx);
                end
            end
        end
    end

    task automatic send(input logic [1:0] b, input logic last, output int acc);
        in_valid = 1'b1;
        in_base  = b;
        in_last  = last;
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_base  = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic v, input logic d, input logic [7:0] k,
                        input logic [IW-1:0] idx, input int acc);
        exp_t e;
        e.v  = v;
        e.d  = d;
        e.at = acc + 2;
        if (v) begin
            held_sig = hash_ref(32'(canon(k)));
            held_idx = idx;
        end
        e.sig = held_sig;
        e.idx = held_idx;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        total++;
        assert (sb.size() == 0) else begin
            bad++; $error("FAIL drain_%s pending=%0d required 0", tag, sb.size());
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        assert ({valid_out, signature_out, index_out, seq_done} === '0) else begin
            bad++;
            $error("FAIL reset_%s valid=%b sig=%h idx=%0d done=%b required all 0",
                   tag, valid_out, signature_out, index_out, seq_done);
        end
    endtask

    initial begin
        int a;
        int gap;
        logic [1:0] acgtac [6];
        acgtac = '{BASE_A, BASE_C, BASE_G, BASE_T, BASE_A, BASE_C};

        // reset held from time 0, then release and stay idle
        idle(3);
        check_zero("initial");
        rst = 1'b0;
        idle(10);
        drain("idle");

        // continuous and gapped ACGTAC, in_last on the final C
        for (int pass = 0; pass < 2; pass++) begin
            gap = (pass == 0) ? 0 : 2;
            for (int i = 0; i < 6; i++) begin
                send(acgtac[i], i == 5, a);
                if (i == 3) push(1'b1, 1'b0, 8'h1B, 10'd0, a);
                if (i == 4) push(1'b1, 1'b0, 8'h6C, 10'd1, a);
                if (i == 5) push(1'b1, 1'b1, 8'hB1, 10'd2, a);
                idle(gap);
            end
            drain(pass == 0 ? "stream" : "gapped");
        end

        // short sequence: seq_done alone, outputs hold previous values
        send(BASE_A, 1'b0, a);
        send(BASE_C, 1'b0, a);
        send(BASE_G, 1'b1, a);
        push(1'b0, 1'b1, 8'h00, 10'd0, a);
        for (int i = 0; i < 4; i++) send(BASE_A, i == 3, a);
        push(1'b1, 1'b1, 8'h00, 10'd0, a);
        drain("short_then_aaaa");

        // TTTT: forward 0xFF, canonical form is AAAA
        for (int i = 0; i < 4; i++) send(BASE_T, i == 3, a);
        push(1'b1, 1'b1, 8'hFF, 10'd0, a);
        drain("tttt");

        // reset pulse one cycle after the 4th base drops the in-flight K-mer
        send(BASE_A, 1'b0, a);
        send(BASE_C, 1'b0, a);
        send(BASE_G, 1'b0, a);
        send(BASE_T, 1'b0, a);
        idle(1);
        rst = 1'b1;
        #2;
        check_zero("pulse");
        rst = 1'b0;
        held_sig = '0;
        held_idx = '0;
        idle(6);
        drain("after_pulse");

        // refeed starts at index 0
        for (int i = 0; i < 4; i++) send(BASE_G, i == 3, a);
        push(1'b1, 1'b1, 8'hAA, 10'd0, a);
        drain("refeed");

        // mid-clock async reset clears held outputs immediately
        #3;
        rst = 1'b1;
        #1;
        check_zero("midclock");
        #1;
        rst = 1'b0;
        held_sig = '0;
        held_idx = '0;
        @(posedge clk);
        #1;
        idle(10);
        drain("final");
        check_zero("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
